// File: rtl/code_patch_loader.sv
// Purpose: collects patch sub-register words into a shadow file, then streams them to the patch core and arms generation.
// Latency: first word valid one cycle after an accepted commit; arm pulse NUM_REGS+1 cycles after commit at full rate.
// Backpressure: the stream holds its word while pat_ready_i is low; ld_ready_o is low outside IDLE.
module code_patch_loader #(
  parameter int ADDR_WIDTH          = 32,
  parameter int DATA_WIDTH          = 12,
  parameter int NUM_REGS            = 21,
  parameter int SUB_REGS_DATA_WIDTH = (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH,
  parameter int IDX_WIDTH           = $clog2(NUM_REGS)
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           ld_valid_i,
  output logic                           ld_ready_o,
  input  logic [IDX_WIDTH-1:0]           ld_idx_i,
  input  logic [SUB_REGS_DATA_WIDTH-1:0] ld_data_i,
  input  logic                           ld_commit_i,
  input  logic                           ld_abort_i,
  input  logic                           err_clr_i,
  output logic                           pat_valid_o,
  input  logic                           pat_ready_i,
  output logic [IDX_WIDTH-1:0]           pat_idx_o,
  output logic [SUB_REGS_DATA_WIDTH-1:0] ctl_pat_data_o,
  output logic                           cfg_pat_gen_o,
  output logic                           busy_o,
  output logic [1:0]                     err_o,
  output logic [7:0]                     patch_cnt_o
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_GEN    = 2'd2
  } state_t;

  localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(NUM_REGS - 1);

  state_t                         state;
  logic [NUM_REGS-1:0]            bitmap;
  logic [SUB_REGS_DATA_WIDTH-1:0] shadow [NUM_REGS];
  logic [IDX_WIDTH-1:0]           idx;

  logic                           in_idle;
  logic                           in_stream;
  logic                           in_gen;
  logic                           idx_in_range;
  logic                           ld_fire;
  logic                           ld_err;
  logic                           bitmap_full;
  logic                           commit_fire;
  logic                           commit_err;
  logic                           idle_abort;
  logic                           stream_abort;
  logic                           pat_fire;
  logic                           last_word;
  logic [IDX_WIDTH-1:0]           idx_next;
  logic [SUB_REGS_DATA_WIDTH-1:0] first_word;
  logic [1:0]                     err_set;

  assign in_idle   = (state == ST_IDLE);
  assign in_stream = (state == ST_STREAM);
  assign in_gen    = (state == ST_GEN);

  // Loads are only taken in IDLE; abort outranks any same-cycle load or commit.
  assign ld_ready_o   = in_idle;
  assign idx_in_range = (int'(ld_idx_i) < NUM_REGS);
  assign ld_fire      = in_idle && !ld_abort_i && ld_valid_i && idx_in_range;
  assign ld_err       = in_idle && !ld_abort_i && ld_valid_i && !idx_in_range;

  // Commit looks at the bitmap as registered before this cycle, so a same-cycle load is not counted.
  assign bitmap_full  = &bitmap;
  assign commit_fire  = in_idle && !ld_abort_i && ld_commit_i && bitmap_full;
  assign commit_err   = in_idle && !ld_abort_i && ld_commit_i && !bitmap_full;

  assign idle_abort   = in_idle && ld_abort_i;
  assign stream_abort = in_stream && ld_abort_i;

  assign pat_fire     = pat_valid_o && pat_ready_i;
  assign last_word    = (idx == LAST_IDX);
  assign idx_next     = idx + IDX_WIDTH'(1);

  // A same-cycle write to word 0 must still reach the first streamed word.
  assign first_word   = (ld_fire && (ld_idx_i == '0)) ? ld_data_i : shadow[0];

  assign err_set      = {commit_err || stream_abort, ld_err};
  assign pat_idx_o    = idx;

  // Shadow file: storage only, contents are meaningless until the matching bitmap bit is set.
  always_ff @(posedge clk_i) begin
    if (ld_fire) begin
      shadow[ld_idx_i] <= ld_data_i;
    end
  end

  // Valid bitmap: one bit per loaded word, emptied by abort, by the arm cycle and by reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      bitmap <= '0;
    end else if (idle_abort || stream_abort || in_gen) begin
      bitmap <= '0;
    end else if (ld_fire) begin
      bitmap <= bitmap | (NUM_REGS'(1) << ld_idx_i);
    end
  end

  // Control FSM with registered stream, arm and busy outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state          <= ST_IDLE;
      idx            <= '0;
      pat_valid_o    <= 1'b0;
      ctl_pat_data_o <= '0;
      cfg_pat_gen_o  <= 1'b0;
      busy_o         <= 1'b0;
    end else begin
      cfg_pat_gen_o <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (commit_fire) begin
            state          <= ST_STREAM;
            idx            <= '0;
            pat_valid_o    <= 1'b1;
            ctl_pat_data_o <= first_word;
            busy_o         <= 1'b1;
          end
        end
        ST_STREAM: begin
          if (ld_abort_i) begin
            // Abort drops the set: no arm pulse and the word in flight is withdrawn.
            state       <= ST_IDLE;
            pat_valid_o <= 1'b0;
            busy_o      <= 1'b0;
          end else if (pat_fire) begin
            if (last_word) begin
              state         <= ST_GEN;
              pat_valid_o   <= 1'b0;
              cfg_pat_gen_o <= 1'b1;
            end else begin
              // Next word is presented straight away so a ready core sees no bubble.
              idx            <= idx_next;
              ctl_pat_data_o <= shadow[idx_next];
            end
          end
        end
        ST_GEN: begin
          state  <= ST_IDLE;
          busy_o <= 1'b0;
        end
        default: begin
          state       <= ST_IDLE;
          pat_valid_o <= 1'b0;
          busy_o      <= 1'b0;
        end
      endcase
    end
  end

  // Completed-set counter, bumped once per arm cycle and wrapping naturally at 8 bits.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      patch_cnt_o <= '0;
    end else if (in_gen) begin
      patch_cnt_o <= patch_cnt_o + 8'd1;
    end
  end

  // Sticky errors: a new error in the clear cycle survives the clear.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      err_o <= '0;
    end else begin
      err_o <= (err_clr_i ? 2'b00 : err_o) | err_set;
    end
  end

endmodule
